// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared constants for the EXU writeback arbiter: default sizes and requester slots.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Optional feature macro used by the top: E203_WBCK_ARB_PERF_EN (per-requester stall counters).
package e203_exu_wbck_arb_pkg;

    // Default number of writeback sources and data/index widths.
    localparam int WBCK_N_REQ   = 3;
    localparam int WBCK_XLEN    = 32;
    localparam int WBCK_RFIDX_W = 5;

    // Stall counter width and its saturation value.
    localparam int          PERF_CNT_W   = 16;
    localparam logic [15:0] PERF_CNT_MAX = 16'hFFFF;

    // Fixed requester slot assignment in the default configuration.
    typedef enum logic [2:0] {
        WBCK_SLOT_ALU = 3'd0,
        WBCK_SLOT_LSU = 3'd1,
        WBCK_SLOT_MDV = 3'd2
    } wbck_slot_e;

    // Round-robin pointer width; at least one bit even for two requesters.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/e203_gnrl_rr_arb.sv
// Combinational round-robin arbiter: grants the first set req bit searching ptr, ptr+1, ... mod N.
// Latency: zero (purely combinational); next_ptr is the slot after the winner.
// Backpressure: none internally; an all-zero req yields gnt=0 and next_ptr=ptr.
// Ports: req (request vector), ptr (search start), gnt (one-hot or zero), next_ptr.
module e203_gnrl_rr_arb #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    always_comb begin
        int   slot;
        logic found;
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        slot     = 0;
        for (int k = 0; k < N; k++) begin
            slot = (int'(ptr) + k) % N;
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                next_ptr  = PW'((slot + 1) % N);
            end
        end
    end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Shares the single register-file write port among N_REQ writeback sources, round-robin.
// Latency: exactly one cycle from accept (valid & ready) to register-file write; one write per cycle.
// Backpressure: req_ready is one-hot or zero, combinational from req_valid/rr_ptr/wbck_hold; hold blocks all grants.
// Ports: clk/rst (async active-high), wbck_hold, req_valid/req_ready/req_idx/req_dat (slice i per requester),
//        wbck_dest_wen/idx/dat to the register file, pend_vld/pend_idx for dispatch RAW hazard checks.
// Optional macro E203_WBCK_ARB_PERF_EN adds perf_clr and perf_stall_cnt (16-bit saturating per requester).
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int N_REQ   = WBCK_N_REQ,
    parameter int XLEN    = WBCK_XLEN,
    parameter int RFIDX_W = WBCK_RFIDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbck_hold,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*RFIDX_W-1:0] req_idx,
    input  logic [N_REQ*XLEN-1:0]    req_dat,
    output logic                     wbck_dest_wen,
    output logic [RFIDX_W-1:0]       wbck_dest_idx,
    output logic [XLEN-1:0]          wbck_dest_dat,
    output logic                     pend_vld,
`ifdef E203_WBCK_ARB_PERF_EN
    input  logic                     perf_clr,
    output logic [N_REQ*16-1:0]      perf_stall_cnt,
`endif
    output logic [RFIDX_W-1:0]       pend_idx
);

    localparam int PTR_W = ptr_width(N_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [N_REQ-1:0]   arb_req;
    logic [N_REQ-1:0]   gnt;
    logic               xfer;
    logic [RFIDX_W-1:0] win_idx;
    logic [XLEN-1:0]    win_dat;

    logic               stage_vld;
    logic [RFIDX_W-1:0] stage_idx;
    logic [XLEN-1:0]    stage_dat;

    // Hold masks requests before arbitration so no grant and no pointer move can happen.
    assign arb_req = wbck_hold ? '0 : req_valid;

    e203_gnrl_rr_arb #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_rr_arb (
        .req      (arb_req),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // gnt is one-hot, so an AND-OR mux selects the winner's payload.
    always_comb begin
        win_idx = '0;
        win_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_idx = win_idx | ({RFIDX_W{gnt[i]}} & req_idx[i*RFIDX_W +: RFIDX_W]);
            win_dat = win_dat | ({XLEN{gnt[i]}}    & req_dat[i*XLEN +: XLEN]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= next_ptr;
        end
    end

    // Stage register: holds the accepted write for exactly one cycle. Reset clears
    // stage_vld asynchronously, so an in-flight write never reaches the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= 1'b0;
            stage_idx <= '0;
            stage_dat <= '0;
        end else begin
            stage_vld <= xfer;
            if (xfer) begin
                stage_idx <= win_idx;
                stage_dat <= win_dat;
            end
        end
    end

    // Writes to x0 are accepted but never reach the port and never create a hazard.
    assign wbck_dest_wen = stage_vld & (stage_idx != '0);
    assign wbck_dest_idx = stage_idx;
    assign wbck_dest_dat = stage_dat;
    assign pend_vld      = stage_vld & (stage_idx != '0);
    assign pend_idx      = stage_idx;

`ifdef E203_WBCK_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt [N_REQ];

    // A stall is a cycle where the requester is valid but not granted (including hold).
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stall_cnt[gi] <= '0;
            end else if (perf_clr) begin
                stall_cnt[gi] <= '0;
            end else if (req_valid[gi] && !req_ready[gi] && (stall_cnt[gi] != PERF_CNT_MAX)) begin
                stall_cnt[gi] <= stall_cnt[gi] + 1'b1;
            end
        end
        assign perf_stall_cnt[gi*16 +: 16] = stall_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench for e203_exu_wbck_arb: directed scenarios plus random traffic vs a reference model.
// Latency: the model expects each accepted write on the port one cycle after acceptance.
// Backpressure: requesters hold valid/idx/dat until granted; the model predicts ready each cycle.
module tb_e203_exu_wbck_arb;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wbck_hold = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_idx = '0;
    logic [N*XL-1:0] req_dat = '0;
    logic            wbck_dest_wen;
    logic [RW-1:0]   wbck_dest_idx;
    logic [XL-1:0]   wbck_dest_dat;
    logic            pend_vld;
    logic [RW-1:0]   pend_idx;
`ifdef E203_WBCK_ARB_PERF_EN
    logic            perf_clr = 1'b0;
    logic [N*16-1:0] perf_stall_cnt;
`endif

    e203_exu_wbck_arb #(.N_REQ(N), .XLEN(XL), .RFIDX_W(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wbck_hold     (wbck_hold),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_idx       (req_idx),
        .req_dat       (req_dat),
        .wbck_dest_wen (wbck_dest_wen),
        .wbck_dest_idx (wbck_dest_idx),
        .wbck_dest_dat (wbck_dest_dat),
        .pend_vld      (pend_vld),
`ifdef E203_WBCK_ARB_PERF_EN
        .perf_clr      (perf_clr),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .pend_idx      (pend_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pointer as an integer, the staged write, and stall counts.
    int            m_ptr;
    bit            m_vld;
    logic [RW-1:0] m_idx;
    logic [XL-1:0] m_dat;
    int            m_cnt [N];
    int            last_g;

    function automatic int exp_grant();
        if (wbck_hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_vld = 0;
        m_idx = '0;
        m_dat = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: inputs are already driven (after a negedge); check ready, clock, check outputs.
    task automatic step();
        int            g;
        logic [N-1:0]  er;
        #1;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        #1;
`ifdef E203_WBCK_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            if (perf_clr) m_cnt[i] = 0;
            else if (req_valid[i] && !er[i] && m_cnt[i] < 65535) m_cnt[i]++;
        end
`endif
        if (g >= 0) begin
            m_vld = 1;
            m_idx = req_idx[g*RW +: RW];
            m_dat = req_dat[g*XL +: XL];
            m_ptr = (g + 1) % N;
        end else begin
            m_vld = 0;
        end
        chk("wen", 64'(wbck_dest_wen), 64'(m_vld && (m_idx != 0)));
        chk("pend_vld", 64'(pend_vld), 64'(m_vld && (m_idx != 0)));
        if (m_vld) begin
            chk("dest_idx", 64'(wbck_dest_idx), 64'(m_idx));
            chk("dest_dat", 64'(wbck_dest_dat), 64'(m_dat));
            chk("pend_idx", 64'(pend_idx), 64'(m_idx));
        end
`ifdef E203_WBCK_ARB_PERF_EN
        for (int i = 0; i < N; i++)
            chk("perf_cnt", 64'(perf_stall_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        last_g = g;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] idx, input logic [XL-1:0] dat);
        req_valid[i]          = 1'b1;
        req_idx[i*RW +: RW]   = idx;
        req_dat[i*XL +: XL]   = dat;
    endtask

    initial begin
        model_reset();
        last_g = -1;
        // Reset state.
        #2;
        chk("rst_wen", 64'(wbck_dest_wen), 64'd0);
        chk("rst_pend", 64'(pend_vld), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_idx", 64'(wbck_dest_idx), 64'd0);
        chk("rst_dat", 64'(wbck_dest_dat), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 0, then idle.
        set_req(0, 5'd5, 32'hDEADBEEF);
        step();
        chk("single_grant", 64'(last_g), 64'd0);
        req_valid = '0;
        step();
        step();

        // All valid for six cycles, distinct destinations.
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        for (int c = 0; c < 6; c++) step();
        req_valid = '0;
        step();

        // Write to x0 from requester 1: accepted, dropped, pointer still moves.
        set_req(1, 5'd0, 32'h1234);
        step();
        req_valid = '0;
        set_req(0, 5'd4, 32'hA0);
        set_req(1, 5'd5, 32'hA1);
        set_req(2, 5'd6, 32'hA2);
        step();
        chk("after_x0_grant", 64'(last_g), 64'd2);

        // Same destination back-to-back: both writes appear in order.
        req_valid = '0;
        set_req(0, 5'd9, 32'h0000_0001);
        step();
        req_valid = '0;
        set_req(1, 5'd9, 32'h0000_0002);
        step();
        chk("last_write_dat", 64'(wbck_dest_dat), 64'h2);
        req_valid = '0;

        // Hold with all valid for three cycles, then release.
        set_req(0, 5'd7, 32'hB0);
        set_req(1, 5'd8, 32'hB1);
        set_req(2, 5'd10, 32'hB2);
        wbck_hold = 1'b1;
        for (int c = 0; c < 3; c++) step();
        wbck_hold = 1'b0;
        step();
        req_valid = '0;

        // Reset while a write is staged: wen must drop without waiting for a clock.
        set_req(2, 5'd11, 32'hC0FFEE);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_wen", 64'(wbck_dest_wen), 64'd0);
        chk("midrst_pend", 64'(pend_vld), 64'd0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 5'd12, 32'hD0);
        set_req(1, 5'd13, 32'hD1);
        set_req(2, 5'd14, 32'hD2);
        step();
        chk("post_rst_grant", 64'(last_g), 64'd0);
        req_valid = '0;
        step();

`ifdef E203_WBCK_ARB_PERF_EN
        // Requester 2 stalls behind 0 and 1, then a clear.
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        set_req(2, 5'd15, 32'hE2);
        wbck_hold = 1'b1;
        for (int c = 0; c < 2; c++) step();
        wbck_hold = 1'b0;
        set_req(0, 5'd16, 32'hE0);
        set_req(1, 5'd17, 32'hE1);
        // Pointer is 1 here: grants go 1, 2 ... keep 0/1 re-asserted to delay 2.
        step();
        chk("perf_stall2_partial", 64'(perf_stall_cnt[2*16 +: 16]), 64'd3);
        req_valid = '0;
        perf_clr = 1'b1;
        step();
        chk("perf_clr", 64'(perf_stall_cnt[2*16 +: 16]), 64'd0);
        perf_clr = 1'b0;
`endif

        // Random traffic: requesters hold their payload until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    set_req(i, (($urandom % 6) == 0) ? 5'd0 : RW'($urandom % 32), $urandom);
                end
            end
            wbck_hold = (($urandom % 8) == 0);
`ifdef E203_WBCK_ARB_PERF_EN
            perf_clr = (($urandom % 16) == 0);
`endif
            step();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        req_valid = '0;
        wbck_hold = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
